// File: rtl/axrm_pkg.sv
// Shared definitions for the AxRM approximate-multiplier characterisation blocks.
// Holds the operand and product widths, the exhaustive sweep length and the
// matching operand/product types used by the monitors and helper units.
package axrm_pkg;

    localparam int W           = 8;
    localparam int PROD_W      = 2 * W;
    localparam int TOTAL_SWEEP = 65536;   // every (a,b) pair of two W-bit operands

    typedef logic [W-1:0]      operand_t;
    typedef logic [PROD_W-1:0] prod_t;

endpackage

// File: rtl/axrm_ed_unit.sv
// Error-distance unit: |x - y| as an unsigned magnitude plus a non-zero flag.
// Latency: combinational, no registers.
// Backpressure: none, pure function of its inputs.
// Ports: x, y (WIDTH) operands; ed (WIDTH) absolute difference; nz high when x != y.
module axrm_ed_unit
    import axrm_pkg::*;
#(
    parameter int WIDTH = PROD_W
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] ed,
    output logic             nz
);

    // Subtract the smaller from the larger so the result always fits in WIDTH
    // bits without needing a sign bit.
    always_comb begin
        ed = '0;
        nz = 1'b0;
        if (x >= y) begin
            ed = x - y;
        end else begin
            ed = y - x;
        end
        nz = (x != y);
    end

endmodule

// File: rtl/axrm_error_monitor.sv
// Error-statistics monitor for approximate multipliers: exact product vs approx, ED count/sum/max.
// Latency: statistics reflect a sample 2 rising edges after acceptance; 1 sample/cycle throughput.
// Backpressure: in_ready is high until TOTAL samples are accepted, then low until rst/clear.
// Ports: clk, rst (sync, active-high), clear (sync restart); in_valid/in_ready handshake with
//        in_a, in_b (W) and in_approx (2W); outputs sample_cnt, err_cnt (CNT_W), sum_ed (SUM_W,
//        saturating), max_ed (2W), last_err and done.
module axrm_error_monitor #(
    parameter int W     = axrm_pkg::W,
    parameter int TOTAL = axrm_pkg::TOTAL_SWEEP,
    parameter int CNT_W = 17,
    parameter int SUM_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_a,
    input  logic [W-1:0]       in_b,
    input  logic [2*W-1:0]     in_approx,
    output logic [CNT_W-1:0]   sample_cnt,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [SUM_W-1:0]   sum_ed,
    output logic [2*W-1:0]     max_ed,
    output logic               last_err,
    output logic               done
);

    localparam int PW = 2 * W;

    logic              restart;
    logic              accept;
    logic [CNT_W-1:0]  issue_cnt;

    // Stage 1 registers
    logic              v1;
    logic [PW-1:0]     exact_q;
    logic [PW-1:0]     approx_q;

    // Stage 2 combinational terms
    logic [PW-1:0]     ed;
    logic              ed_nz;
    logic [SUM_W:0]    sum_wide;

    assign restart  = rst | clear;
    // in_ready depends only on the issue count, never on in_valid.
    assign in_ready = (issue_cnt != CNT_W'(TOTAL));
    assign accept   = in_valid & in_ready;

    // Stage 1 control: a restart wins over a same-cycle acceptance and drops
    // whatever was in flight.
    always_ff @(posedge clk) begin
        if (restart) begin
            issue_cnt <= '0;
            v1        <= 1'b0;
        end else begin
            v1 <= accept;
            if (accept) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
        end
    end

    // Stage 1 datapath: exact product is a behavioural reference, not a
    // modelled multiplier. Data is only meaningful while v1 is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            exact_q  <= PW'(in_a) * PW'(in_b);
            approx_q <= in_approx;
        end
    end

    axrm_ed_unit #(
        .WIDTH (PW)
    ) u_ed (
        .x  (exact_q),
        .y  (approx_q),
        .ed (ed),
        .nz (ed_nz)
    );

    // One spare bit catches the carry-out that signals saturation.
    assign sum_wide = {1'b0, sum_ed} + (SUM_W + 1)'(ed);

    // Stage 2: fold the retiring sample into the statistics.
    always_ff @(posedge clk) begin
        if (restart) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            sum_ed     <= '0;
            max_ed     <= '0;
            last_err   <= 1'b0;
            done       <= 1'b0;
        end else if (v1) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
            if (ed_nz) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
            sum_ed   <= sum_wide[SUM_W] ? '1 : sum_wide[SUM_W-1:0];
            if (ed > max_ed) begin
                max_ed <= ed;
            end
            last_err <= ed_nz;
            // The TOTAL-th retirement is necessarily the last one in flight,
            // so the pipeline is empty on the same edge.
            if (sample_cnt == CNT_W'(TOTAL - 1)) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axrm_error_monitor.sv
module tb_axrm_error_monitor;

    localparam int     W       = 8;
    localparam int     TOTAL   = 64;
    localparam int     CNT_W   = 8;
    localparam int     SUM_W   = 20;
    localparam longint SUM_MAX = (64'd1 << SUM_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               clear;
    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       in_a;
    logic [W-1:0]       in_b;
    logic [2*W-1:0]     in_approx;
    logic [CNT_W-1:0]   sample_cnt;
    logic [CNT_W-1:0]   err_cnt;
    logic [SUM_W-1:0]   sum_ed;
    logic [2*W-1:0]     max_ed;
    logic               last_err;
    logic               done;

    axrm_error_monitor #(
        .W     (W),
        .TOTAL (TOTAL),
        .CNT_W (CNT_W),
        .SUM_W (SUM_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_approx  (in_approx),
        .sample_cnt (sample_cnt),
        .err_cnt    (err_cnt),
        .sum_ed     (sum_ed),
        .max_ed     (max_ed),
        .last_err   (last_err),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: running statistics after every accepted sample.
    typedef struct {
        longint cnt;
        longint err;
        longint sum;
        longint mx;
        bit     last;
        bit     dn;
        int     cyc;
    } exp_t;

    exp_t   q[$];
    longint m_cnt, m_err, m_sum, m_max;
    bit     m_last;
    int     issued;
    bit     started = 1'b0;

    task automatic model_reset();
        m_cnt = 0; m_err = 0; m_sum = 0; m_max = 0; m_last = 0; issued = 0;
        q.delete();
    endtask

    task automatic model_accept(input int a, input int b, input int ap);
        longint ex, d;
        exp_t   e;
        ex = longint'(a) * longint'(b);
        d  = (ex > ap) ? ex - ap : longint'(ap) - ex;
        issued++;
        m_cnt++;
        if (d != 0) m_err++;
        m_sum = m_sum + d;
        if (m_sum > SUM_MAX) m_sum = SUM_MAX;
        if (d > m_max) m_max = d;
        m_last = (d != 0);
        e.cnt = m_cnt; e.err = m_err; e.sum = m_sum; e.mx = m_max; e.last = m_last;
        e.dn  = (m_cnt == TOTAL);
        e.cyc = cyc + 2;
        q.push_back(e);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic drive_cycle(input bit v, input int a, input int b, input int ap, input bit clr);
        chk("in_ready", in_ready, (issued != TOTAL));
        in_valid  = v;
        in_a      = a[W-1:0];
        in_b      = b[W-1:0];
        in_approx = ap[2*W-1:0];
        clear     = clr;
        if (!clr && v && issued != TOTAL) model_accept(a, b, ap);
        @(posedge clk);
        #1;
        if (clr) model_reset();
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_sample_cnt"}, sample_cnt, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
        chk({tag, "_sum_ed"}, sum_ed, 0);
        chk({tag, "_max_ed"}, max_ed, 0);
        chk({tag, "_last_err"}, last_err, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
    endtask

    task automatic do_clear();
        drive_cycle(0, 0, 0, 0, 1);
        chk_zero("clear");
    endtask

    task automatic rand_sample(output int a, output int b, output int ap);
        int mode;
        a    = $urandom_range(0, 255);
        b    = $urandom_range(0, 255);
        mode = $urandom_range(0, 3);
        case (mode)
            0:       ap = a * b;
            1:       ap = (a * b + $urandom_range(0, 8) - 4) & 16'hFFFF;
            2:       ap = $urandom_range(0, 65535);
            default: ap = 0;
        endcase
    endtask

    // Monitor: whenever the DUT retires a sample, compare against the oldest expectation.
    int   prev_cnt = 0;
    exp_t e;
    always @(negedge clk) begin
        if (started && (sample_cnt != CNT_W'(prev_cnt))) begin
            if (sample_cnt == 0) begin
                // restart; zero state is checked by the stimulus side
            end else if (q.size() == 0) begin
                chk("unexpected_retire", sample_cnt, prev_cnt);
            end else begin
                e = q.pop_front();
                chk("sb_sample_cnt", sample_cnt, e.cnt);
                chk("sb_err_cnt", err_cnt, e.err);
                chk("sb_sum_ed", sum_ed, e.sum);
                chk("sb_max_ed", max_ed, e.mx);
                chk("sb_last_err", last_err, e.last);
                chk("sb_done", done, e.dn);
                chk("sb_latency_cycle", cyc, e.cyc);
            end
            prev_cnt = int'(sample_cnt);
        end
    end

    initial begin
        int a, b, ap;
        longint s_cnt, s_err, s_sum, s_max;
        bit     s_last;

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
        in_a = '0; in_b = '0; in_approx = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_zero("reset");
        started = 1'b1;

        // Exact sample: counted but not an error.
        drive_cycle(1, 3, 3, 9, 0);
        idle(3);
        chk("t1_sample_cnt", sample_cnt, 1);
        chk("t1_err_cnt", err_cnt, 0);
        chk("t1_sum_ed", sum_ed, 0);
        chk("t1_max_ed", max_ed, 0);
        chk("t1_last_err", last_err, 0);

        // Single erroneous sample.
        do_clear();
        drive_cycle(1, 3, 3, 7, 0);
        idle(3);
        chk("t2_err_cnt", err_cnt, 1);
        chk("t2_sum_ed", sum_ed, 2);
        chk("t2_max_ed", max_ed, 2);
        chk("t2_last_err", last_err, 1);

        // Largest possible ED followed by a small one.
        do_clear();
        drive_cycle(1, 255, 255, 0, 0);
        drive_cycle(1, 2, 2, 5, 0);
        idle(3);
        chk("t3_max_ed", max_ed, 65025);
        chk("t3_sum_ed", sum_ed, 65026);
        chk("t3_err_cnt", err_cnt, 2);
        chk("t3_sample_cnt", sample_cnt, 2);

        // Clear while streaming with in_valid high: everything in flight is dropped.
        do_clear();
        for (int i = 0; i < 4; i++) begin
            rand_sample(a, b, ap);
            drive_cycle(1, a, b, ap, 0);
        end
        rand_sample(a, b, ap);
        drive_cycle(1, a, b, ap, 1);
        chk_zero("midclear");
        idle(3);
        chk("midclear_sample_cnt_later", sample_cnt, 0);
        chk("midclear_sum_later", sum_ed, 0);

        // Full run to TOTAL with back-to-back valid; early huge errors saturate sum_ed.
        do_clear();
        for (int i = 0; i < TOTAL + 6; i++) begin
            if (i < 20) begin
                a = 255; b = 255; ap = 0;
            end else begin
                rand_sample(a, b, ap);
            end
            drive_cycle(1, a, b, ap, 0);
        end
        idle(3);
        chk("t4_done", done, 1);
        chk("t4_sample_cnt", sample_cnt, TOTAL);
        chk("t4_sum_saturated", sum_ed, SUM_MAX);
        chk("t4_in_ready", in_ready, 0);
        chk("t4_accepted", issued, TOTAL);

        // After done, further samples must not move any statistic.
        s_cnt = m_cnt; s_err = m_err; s_sum = m_sum; s_max = m_max; s_last = m_last;
        for (int i = 0; i < 5; i++) begin
            rand_sample(a, b, ap);
            drive_cycle(1, a, b, ap, 0);
        end
        idle(3);
        chk("post_done_sample_cnt", sample_cnt, s_cnt);
        chk("post_done_err_cnt", err_cnt, s_err);
        chk("post_done_sum_ed", sum_ed, s_sum);
        chk("post_done_max_ed", max_ed, s_max);
        chk("post_done_last_err", last_err, s_last);
        chk("post_done_done", done, 1);

        // Random traffic with gaps and occasional restarts.
        do_clear();
        for (int i = 0; i < 600; i++) begin
            rand_sample(a, b, ap);
            if ($urandom_range(0, 99) < 2) begin
                drive_cycle($urandom_range(0, 1), a, b, ap, 1);
                chk_zero("rnd_clear");
            end else begin
                drive_cycle(($urandom_range(0, 99) < 75), a, b, ap, 0);
            end
        end

        // Drain with a bounded wait.
        for (int i = 0; i < 10 && q.size() != 0; i++) idle(1);
        chk("drain_queue_empty", q.size(), 0);
        chk("final_sample_cnt", sample_cnt, m_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
